// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
//   Parametrised in-order pipeline latch chain. STAGES payload registers, each
//   with a valid bit, shift one stage per advancing cycle. Supports per-stage
//   flush, load-use bubble insertion after BUBBLE_STAGE, ihit/dhit stall gating
//   with a sticky dhit, and a sticky halt raised when a halt-flagged entry sits
//   valid in the last stage.
//
//   Optional feature: define PIPE_PERF_EN to add three wrapping 32-bit
//   performance counters (stall_cnt, bubble_cnt, flush_cnt) and their ports.
//
// Ports
//   CLK, RST      clock (rising edge), asynchronous active-high reset
//   in_valid/in_data/in_ready   fetch payload in; in_ready = slot consumed
//   ihit          instruction hit, global advance enable
//   dmem_req/dhit/dmemload      data access handshake for the MEM_STAGE entry
//   dload_q       dmemload captured on every dhit
//   flush_mask    bit s squashes the entry currently in stage s
//   bubble        load-use stall request
//   advance       chain shifts at the next edge (combinational)
//   stage_valid/stage_data      per-stage valid and flat payloads
//   halt          sticky halt
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
    parameter int WIDTH        = 32,
    parameter int STAGES       = 4,
    parameter int MEM_STAGE    = 2,
    parameter int BUBBLE_STAGE = 0,
    parameter int HALT_BIT     = 31
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    input  logic                      ihit,
    input  logic                      dmem_req,
    input  logic                      dhit,
    input  logic [WIDTH-1:0]          dmemload,
    output logic [WIDTH-1:0]          dload_q,
    input  logic [STAGES-1:0]         flush_mask,
    input  logic                      bubble,
    output logic                      advance,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic                      halt
`ifdef PIPE_PERF_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               bubble_cnt,
    output logic [31:0]               flush_cnt
`endif
);

    logic               r_halt;
    logic               r_dhit_seen;
    logic [WIDTH-1:0]   r_dload_q;
    logic [WIDTH-1:0]   w_data [STAGES];
    logic               w_mem_wait;
    logic               w_advance;
    logic               w_bubble;

    // A dhit already seen (or arriving now) releases the memory wait.
    assign w_mem_wait = stage_valid[MEM_STAGE] & dmem_req & ~r_dhit_seen & ~dhit;
    assign w_advance  = ihit & ~w_mem_wait & ~r_halt;
    // Flushing the bubble-source stage removes the hazard, so the bubble is dropped.
    assign w_bubble   = bubble & ~flush_mask[BUBBLE_STAGE];

    assign advance  = w_advance;
    assign in_ready = w_advance & ~w_bubble;
    assign halt     = r_halt;
    assign dload_q  = r_dload_q;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam bit HOLDS_ON_BUBBLE = (s <= BUBBLE_STAGE);
        localparam bit BUBBLE_SLOT     = (s == BUBBLE_STAGE + 1);

        logic             r_valid;
        logic [WIDTH-1:0] r_data;
        logic             w_src_valid;
        logic [WIDTH-1:0] w_src_data;

        if (s == 0) begin : g_head
            assign w_src_valid = in_valid;
            assign w_src_data  = in_data;
        end else begin : g_body
            // The upstream entry's flush applies as it moves down.
            assign w_src_valid = stage_valid[s-1] & ~flush_mask[s-1];
            assign w_src_data  = w_data[s-1];
        end

        // NOTE: payload registers are reset too, so a freshly reset chain shows
        // all-zero data and not just cleared valid bits.
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (w_advance && !(w_bubble && (HOLDS_ON_BUBBLE || BUBBLE_SLOT))) begin
                r_valid <= w_src_valid;
                r_data  <= w_src_valid ? w_src_data : '0;
            end else if (w_advance && w_bubble && BUBBLE_SLOT) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                // Holding stage: data kept, only the valid bit can be squashed.
                r_valid <= r_valid & ~flush_mask[s];
            end
        end

        assign stage_valid[s]              = r_valid;
        assign w_data[s]                   = r_data;
        assign stage_data[s*WIDTH +: WIDTH] = r_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_halt      <= 1'b0;
            r_dhit_seen <= 1'b0;
            r_dload_q   <= '0;
        end else begin
            if (stage_valid[STAGES-1] && w_data[STAGES-1][HALT_BIT])
                r_halt <= 1'b1;
            if (w_advance)
                r_dhit_seen <= 1'b0;
            else if (dhit)
                r_dhit_seen <= 1'b1;
            if (dhit)
                r_dload_q <= dmemload;
        end
    end

`ifdef PIPE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (!w_advance && !r_halt)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_advance && w_bubble)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (|flush_mask)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

endmodule
